r2mdc_delay_commutator: RTL and testbench



---
 rtl/fft_pkg.sv | 16 +
 rtl/delay_line.sv | 24 ++
 rtl/r2mdc_delay_commutator.sv | 86 ++++++++
 tb/tb_r2mdc_delay_commutator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: sample width, Q7.8 fixed-point format, complex sample type.
package fft_pkg;
   localparam int DATA_W    = 16;
   localparam int INT_BITS  = 7;
   localparam int FRAC_BITS = 8;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   // Packed {re, im} word width for a given component width.
   function automatic int cplx_w(input int dw);
      return 2 * dw;
   endfunction
endpackage

// File: rtl/delay_line.sv
// Enabled shift register with synchronous clear; DEPTH=1 is a single register.
module delay_line #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else if (i_en) begin
         r_sr[0] <= i_d;
         for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/r2mdc_delay_commutator.sv
// R2MDC inter-stage reorder: upper-path delay, 2x2 commutator toggling every DELAY
// accepted samples, lower-output delay; emits (A, B) pairs DELAY samples apart.
module r2mdc_delay_commutator #(
   parameter int DELAY  = 4,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_up_re,
   input  logic [DATA_W-1:0] in_up_im,
   input  logic [DATA_W-1:0] in_lo_re,
   input  logic [DATA_W-1:0] in_lo_im,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_a_re,
   output logic [DATA_W-1:0] out_a_im,
   output logic [DATA_W-1:0] out_b_re,
   output logic [DATA_W-1:0] out_b_im,
   output logic [IDX_W-1:0]  out_idx
);
   import fft_pkg::*;

   localparam int CNT_W = $clog2(2 * DELAY);
   localparam int W     = cplx_w(DATA_W);

   logic [CNT_W-1:0] r_cnt;
   logic             r_primed;
   logic [W-1:0]     w_up_in, w_lo_in, w_up_dly, w_c_up, w_c_lo, w_a_dly;
   logic             w_phase;
   logic [IDX_W-1:0] w_idx;

   assign w_up_in = {in_up_re, in_up_im};
   assign w_lo_in = {in_lo_re, in_lo_im};

   // cnt MSB is bit log2(DELAY) since cnt counts modulo 2*DELAY.
   assign w_phase = r_cnt[CNT_W-1];
   assign w_c_up  = w_phase ? w_lo_in  : w_up_dly;
   assign w_c_lo  = w_phase ? w_up_dly : w_lo_in;

   generate
      if (DELAY == 1) begin : g_idx_zero
         assign w_idx = '0;
      end else begin : g_idx_cnt
         assign w_idx = IDX_W'(r_cnt[CNT_W-2:0]);
      end
   endgenerate

   delay_line #(.DEPTH(DELAY), .WIDTH(W)) u_up_dly (
      .clk  (clk),
      .i_clr(rst),
      .i_en (in_valid),
      .i_d  (w_up_in),
      .o_q  (w_up_dly)
   );

   delay_line #(.DEPTH(DELAY), .WIDTH(W)) u_lo_dly (
      .clk  (clk),
      .i_clr(rst),
      .i_en (in_valid),
      .i_d  (w_c_lo),
      .o_q  (w_a_dly)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_primed  <= 1'b0;
         out_valid <= 1'b0;
         out_a_re  <= '0;
         out_a_im  <= '0;
         out_b_re  <= '0;
         out_b_im  <= '0;
         out_idx   <= '0;
      end else begin
         out_valid <= in_valid & r_primed;
         if (in_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DELAY - 1)) r_primed <= 1'b1;
            {out_a_re, out_a_im} <= w_a_dly;
            {out_b_re, out_b_im} <= w_c_up;
            out_idx              <= w_idx;
         end
      end
   end
endmodule

// File: tb/tb_r2mdc_delay_commutator.sv
// Directed scoreboard bench for the R2MDC delay-commutator at DELAY=4 and DELAY=1.
module tb_r2mdc_delay_commutator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v4 = 1'b0, v1 = 1'b0;
   logic [15:0] u4_re = '0, u4_im = '0, l4_re = '0, l4_im = '0;
   logic [15:0] u1_re = '0, u1_im = '0, l1_re = '0, l1_im = '0;
   logic        o4_valid, o1_valid;
   logic [15:0] o4_are, o4_aim, o4_bre, o4_bim;
   logic [15:0] o1_are, o1_aim, o1_bre, o1_bim;
   logic [1:0]  o4_idx;
   logic [0:0]  o1_idx;

   typedef struct {
      logic [15:0] are, aim, bre, bim;
      logic [1:0]  idx;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   n_checks = 0;
   int   n_err    = 0;
   int   g_uoff, g_loff;
   bit   g_neg;

   always #5 clk = ~clk;

   r2mdc_delay_commutator #(.DELAY(4), .DATA_W(16), .IDX_W(2)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4),
      .in_up_re(u4_re), .in_up_im(u4_im), .in_lo_re(l4_re), .in_lo_im(l4_im),
      .out_valid(o4_valid), .out_a_re(o4_are), .out_a_im(o4_aim),
      .out_b_re(o4_bre), .out_b_im(o4_bim), .out_idx(o4_idx)
   );

   r2mdc_delay_commutator #(.DELAY(1), .DATA_W(16), .IDX_W(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1),
      .in_up_re(u1_re), .in_up_im(u1_im), .in_lo_re(l1_re), .in_lo_im(l1_im),
      .out_valid(o1_valid), .out_a_re(o1_are), .out_a_im(o1_aim),
      .out_b_re(o1_bre), .out_b_im(o1_bim), .out_idx(o1_idx)
   );

   function automatic logic [15:0] ure(input int n); return 16'(g_uoff + n); endfunction
   function automatic logic [15:0] lre(input int n); return 16'(g_loff + n); endfunction
   function automatic logic [15:0] uim(input int n); return g_neg ? 16'(-(g_uoff + n)) : 16'h0; endfunction
   function automatic logic [15:0] lim(input int n); return g_neg ? 16'(-(g_loff + n)) : 16'h0; endfunction

   // Pair produced by accepted sample n (n >= d): odd half-windows carry L, even carry U.
   function automatic exp_t model(input int d, input int n);
      exp_t e;
      if (((n / d) % 2) == 1) begin
         e.are = lre(n - d);     e.aim = lim(n - d);
         e.bre = lre(n);         e.bim = lim(n);
      end else begin
         e.are = ure(n - 2 * d); e.aim = uim(n - 2 * d);
         e.bre = ure(n - d);     e.bim = uim(n - d);
      end
      e.idx = 2'(n % d);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic cmp_pop(input string tag, input logic [15:0] are, aim, bre, bim,
                          input logic [1:0] idx);
      exp_t e;
      e = q.pop_front();
      last = e;
      chk({tag, "_a_re"}, 32'(are), 32'(e.are));
      chk({tag, "_a_im"}, 32'(aim), 32'(e.aim));
      chk({tag, "_b_re"}, 32'(bre), 32'(e.bre));
      chk({tag, "_b_im"}, 32'(bim), 32'(e.bim));
      chk({tag, "_idx"},  32'(idx), 32'(e.idx));
   endtask

   task automatic step4(input bit v, input int n);
      bit ev;
      v4 = v;
      if (v) begin
         u4_re = ure(n); u4_im = uim(n); l4_re = lre(n); l4_im = lim(n);
      end
      ev = v && (n >= 4);
      if (ev) q.push_back(model(4, n));
      @(posedge clk); #1;
      chk("valid4", 32'(o4_valid), 32'(ev));
      if (!v) chk("hold4_a_re", 32'(o4_are), 32'(last.are));
      if (o4_valid && q.size() > 0) cmp_pop("d4", o4_are, o4_aim, o4_bre, o4_bim, o4_idx);
   endtask

   task automatic step1(input int n);
      bit ev;
      v1 = 1'b1;
      u1_re = ure(n); u1_im = uim(n); l1_re = lre(n); l1_im = lim(n);
      ev = (n >= 1);
      if (ev) q.push_back(model(1, n));
      @(posedge clk); #1;
      chk("valid1", 32'(o1_valid), 32'(ev));
      if (o1_valid && q.size() > 0) cmp_pop("d1", o1_are, o1_aim, o1_bre, o1_bim, {1'b0, o1_idx});
   endtask

   task automatic do_reset();
      v4 = 1'b0; v1 = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid4"}, 32'(o4_valid), 32'h0);
      chk({tag, "_out4"}, 32'({o4_are, o4_aim} | {o4_bre, o4_bim} | 32'(o4_idx)), 32'h0);
      chk({tag, "_valid1"}, 32'(o1_valid), 32'h0);
      chk({tag, "_out1"}, 32'({o1_are, o1_aim} | {o1_bre, o1_bim} | 32'(o1_idx)), 32'h0);
   endtask

   initial begin
      last = '{default: '0};
      // Reset held 3 cycles with valid data driven
      rst = 1'b1; v4 = 1'b1; v1 = 1'b1;
      u4_re = 16'h1111; l4_re = 16'h2222; u1_re = 16'h3333; l1_re = 16'h4444;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_zero("reset");
      end
      rst = 1'b0; v4 = 1'b0; v1 = 1'b0;

      // Fill and order, continuous 16 samples
      g_uoff = 0; g_loff = 100; g_neg = 1'b1;
      for (int n = 0; n < 16; n++) step4(1'b1, n);

      // Same stream with two 2-cycle stalls
      do_reset();
      for (int n = 0; n < 16; n++) begin
         if (n == 5 || n == 9) begin
            step4(1'b0, n);
            step4(1'b0, n);
         end
         step4(1'b1, n);
      end

      // Back-to-back frames across the boundary
      do_reset();
      for (int n = 0; n < 32; n++) step4(1'b1, n);

      // Mid-stream reset at n=6, then restart with new data
      do_reset();
      for (int n = 0; n < 6; n++) step4(1'b1, n);
      rst = 1'b1; v4 = 1'b1;
      u4_re = ure(6); u4_im = uim(6); l4_re = lre(6); l4_im = lim(6);
      @(posedge clk); #1;
      chk_zero("midrst");
      rst = 1'b0;
      g_uoff = 200; g_loff = 250; g_neg = 1'b0;
      for (int n = 0; n < 12; n++) step4(1'b1, n);
      v4 = 1'b0;

      // DELAY=1 alternating stream
      do_reset();
      g_uoff = 0; g_loff = 50; g_neg = 1'b0;
      for (int n = 0; n < 8; n++) step1(n);
      v1 = 1'b0;

      chk("sb_drain", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
